move_sequencer: RTL and testbench
=================================

// Module: move_sequencer
// PURPOSE
//  Top-level move controller for the connect-four core. Accepts a column drop
//  and scans the board for the landing row. Writes the piece, then sequences
//  victory_checker and records the result (win, draw or next turn). Owns the
//  single board read port and shares it between its own scanner and the checker.
// PARAMETERS
//  ROWS   6   board rows; row 0 is the bottom row
//  COLS   7   board columns; col 0 is the leftmost column
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  asynchronous active-low reset
//  new_game       in   1  synchronous clear of the game state; honoured in any state
//  move_valid     in   1  drop request
//  move_col       in   3  requested column
//  move_ready     out  1  high only in ST_IDLE; a move is accepted when move_valid&&move_ready
//  illegal_move   out  1  1-cycle pulse: column out of range or column full
//  rd_row         out  3  board read row (muxed)
//  rd_col         out  3  board read column (muxed)
//  rd_data        in   2  board cell at rd_row/rd_col, combinational (same cycle)
//  wr_en          out  1  board write strobe, 1 cycle
//  wr_row         out  3  board write row
//  wr_col         out  3  board write column
//  wr_data        out  2  piece written (current player)
//  vc_start       out  1  victory_checker start, 1-cycle pulse
//  vc_row         out  3  landed row, held stable while checking
//  vc_col         out  3  landed column, held stable while checking
//  vc_row_read    in   3  checker read address (row)
//  vc_col_read    in   3  checker read address (col)
//  vc_done        in   1  checker done_checking (high when idle)
//  vc_winner      in   2  checker winner
//  current_player out  2  player to move: 2'b01 P1, 2'b10 P2
//  winner         out  2  00 none, 01 P1, 10 P2, 11 draw
//  game_over      out  1  high from the end of the game until new_game or reset
// BEHAVIOUR
//  Reset values: current_player=01, winner=00, game_over=0, move count=0,
//   state=ST_IDLE. All strobes (wr_en, vc_start, illegal_move) are 0.
//  States and transitions:
//   ST_IDLE: accept a move. If move_col>=COLS, pulse illegal_move next cycle
//    and stay in ST_IDLE. Otherwise latch the column, set scan row=0 and go to ST_SCAN.
//   ST_SCAN: read (scan row, column). If rd_data==00, go to ST_WRITE.
//    Otherwise, if scan row==ROWS-1, pulse illegal_move and go to ST_IDLE
//    (the turn does not change); else increment scan row (one row per cycle).
//   ST_WRITE: wr_en=1 with wr_data=current_player. Latch vc_row/vc_col.
//    Increment the move count. Go to ST_CHECK_START.
//   ST_CHECK_START: vc_start=1 for one cycle. Go to ST_WAIT_BUSY.
//   ST_WAIT_BUSY: wait for vc_done==0, then go to ST_WAIT_DONE.
//   ST_WAIT_DONE: wait for vc_done==1, then go to ST_RESOLVE.
//   ST_RESOLVE:
//    - vc_winner!=00: winner<=vc_winner, game_over<=1, go to ST_OVER.
//    - move count==ROWS*COLS: winner<=11, game_over<=1, go to ST_OVER.
//    - otherwise: toggle current_player (01<->10), go to ST_IDLE.
//   ST_OVER: move_ready=0. Leave only on new_game.
//  Read port arbitration: the checker owns rd_row/rd_col in ST_CHECK_START,
//   ST_WAIT_BUSY and ST_WAIT_DONE. In every other state the scanner owns the port.
//  Latency: a drop into an empty column reaches vc_start on cycle 3 after
//   acceptance (SCAN, WRITE, CHECK_START). Each occupied cell adds 1 cycle.
//  Move count is ceil(log2(ROWS*COLS+1)) bits wide and saturates; it never wraps.
//  Simultaneous events: new_game wins over every other event. It clears
//   winner, game_over and the move count, sets current_player=01 and the
//   state to ST_IDLE. It does not clear the board RAM; the board owner clears
//   the board on the same signal. move_valid in the new_game cycle is ignored.
//  Reset mid-operation: asynchronous return to the reset values; an
//   in-flight write strobe is dropped.
//  A move_valid outside ST_IDLE is not accepted; the requester holds it.
// STRUCTURE
//  Shared package: state encodings, player/winner codes (EMPTY, P1, P2, DRAW)
//   and the ROWS/COLS defaults.
//  No sub-module: a single FSM plus the read mux.
//  Instantiated next to victory_checker and the board RAM by the game top.
// TESTING
//  1 Empty board, move col 3 -> wr_en at (0,3) data 01; vc_start 3 cycles
//    after acceptance; then current_player=10.
//  2 Col 3 holds 01,10 in rows 0-1; move col 3 -> scan takes 3 cycles;
//    wr_row=2.
//  3 Full column 5 -> illegal_move pulse, no wr_en, current_player unchanged.
//    move_col=7 -> illegal_move pulse with no ST_SCAN.
//  4 Model checker returns 01 after done -> winner=01, game_over=1,
//    move_ready=0; move_valid ignored until new_game.
//  5 42 moves with no win -> winner=11; new_game mid-CHECK_WAIT -> state
//    IDLE, player 01, count 0.
//  6 Assert rst_n during ST_SCAN -> all outputs at reset values immediately;
//    during check, rd_row/rd_col track vc_row_read/vc_col_read.

Source files
------------

// File: rtl/move_sequencer_pkg.sv
// Shared definitions for the connect-four move controller.
//   - board geometry defaults (ROWS_DEF / COLS_DEF)
//   - cell / player / winner codes
//   - move sequencer state encoding
//   - helper to hand the turn to the other player
package move_sequencer_pkg;

   localparam int ROWS_DEF = 6;
   localparam int COLS_DEF = 7;

   localparam logic [1:0] PIECE_EMPTY = 2'b00;
   localparam logic [1:0] PIECE_P1    = 2'b01;
   localparam logic [1:0] PIECE_P2    = 2'b10;
   localparam logic [1:0] PIECE_DRAW  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_SCAN        = 3'd1,
      ST_WRITE       = 3'd2,
      ST_CHECK_START = 3'd3,
      ST_WAIT_BUSY   = 3'd4,
      ST_WAIT_DONE   = 3'd5,
      ST_RESOLVE     = 3'd6,
      ST_OVER        = 3'd7
   } state_t;

   function automatic logic [1:0] other_player(input logic [1:0] p);
      return (p == PIECE_P1) ? PIECE_P2 : PIECE_P1;
   endfunction

endpackage

// File: rtl/move_sequencer.sv
// Move controller for the connect-four core. Takes a column drop, scans the
// column bottom-up for the first empty cell, writes the current player's
// piece, runs victory_checker and records win / draw / next turn.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   new_game                   synchronous clear of game state (top priority)
//   move_valid/move_col/move_ready  drop request handshake
//   illegal_move               1-cycle pulse: column out of range or full
//   rd_row/rd_col/rd_data      shared board read port (scanner or checker)
//   wr_en/wr_row/wr_col/wr_data  board write, 1-cycle strobe
//   vc_start/vc_row/vc_col     checker start pulse and landed position
//   vc_row_read/vc_col_read    checker read address
//   vc_done/vc_winner          checker status and result
//   current_player/winner/game_over  game status
//
// state          | meaning
// ---------------+---------------------------------------------------
// ST_IDLE        | waiting for a drop request
// ST_SCAN        | reading one row per cycle for the landing cell
// ST_WRITE       | write strobe active, move counted
// ST_CHECK_START | checker start pulse, checker owns read port
// ST_WAIT_BUSY   | waiting for checker to drop done
// ST_WAIT_DONE   | waiting for checker to raise done
// ST_RESOLVE     | apply checker result / draw / turn change
// ST_OVER        | game finished, only new_game leaves
module move_sequencer
   import move_sequencer_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       new_game,
   input  logic       move_valid,
   input  logic [2:0] move_col,
   output logic       move_ready,
   output logic       illegal_move,
   output logic [2:0] rd_row,
   output logic [2:0] rd_col,
   input  logic [1:0] rd_data,
   output logic       wr_en,
   output logic [2:0] wr_row,
   output logic [2:0] wr_col,
   output logic [1:0] wr_data,
   output logic       vc_start,
   output logic [2:0] vc_row,
   output logic [2:0] vc_col,
   input  logic [2:0] vc_row_read,
   input  logic [2:0] vc_col_read,
   input  logic       vc_done,
   input  logic [1:0] vc_winner,
   output logic [1:0] current_player,
   output logic [1:0] winner,
   output logic       game_over
);

   localparam int              CNT_W     = $clog2(ROWS * COLS + 1);
   localparam logic [CNT_W-1:0] MAX_MOVES = CNT_W'(ROWS * COLS);
   localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
   localparam logic [3:0]      COLS_LIM  = 4'(COLS);
   localparam logic [2:0]      LAST_ROW  = 3'(ROWS - 1);

   state_t           state_q, state_d;
   logic [2:0]       col_q, col_d;
   logic [2:0]       scan_row_q, scan_row_d;
   logic [2:0]       land_row_q, land_row_d;
   logic [2:0]       land_col_q, land_col_d;
   logic [1:0]       player_q, player_d;
   logic [1:0]       winner_q, winner_d;
   logic             game_over_q, game_over_d;
   logic [CNT_W-1:0] move_cnt_q, move_cnt_d;
   logic             wr_en_q, wr_en_d;
   logic             vc_start_q, vc_start_d;
   logic             illegal_q, illegal_d;

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      scan_row_d  = scan_row_q;
      land_row_d  = land_row_q;
      land_col_d  = land_col_q;
      player_d    = player_q;
      winner_d    = winner_q;
      game_over_d = game_over_q;
      move_cnt_d  = move_cnt_q;
      wr_en_d     = 1'b0;
      vc_start_d  = 1'b0;
      illegal_d   = 1'b0;

      // Strobes are registered: they are set on the transition into the
      // state in which they must be visible.
      case (state_q)
         ST_IDLE: begin
            if (move_valid) begin
               if ({1'b0, move_col} >= COLS_LIM) begin
                  illegal_d = 1'b1;
               end else begin
                  col_d      = move_col;
                  scan_row_d = 3'd0;
                  state_d    = ST_SCAN;
               end
            end
         end
         ST_SCAN: begin
            if (rd_data == PIECE_EMPTY) begin
               wr_en_d    = 1'b1;
               land_row_d = scan_row_q;
               land_col_d = col_q;
               state_d    = ST_WRITE;
            end else if (scan_row_q == LAST_ROW) begin
               illegal_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               scan_row_d = scan_row_q + 3'd1;
            end
         end
         ST_WRITE: begin
            move_cnt_d = (move_cnt_q == CNT_SAT) ? move_cnt_q : move_cnt_q + 1'b1;
            vc_start_d = 1'b1;
            state_d    = ST_CHECK_START;
         end
         ST_CHECK_START: state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY:   if (!vc_done) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE:   if (vc_done) state_d = ST_RESOLVE;
         ST_RESOLVE: begin
            if (vc_winner != PIECE_EMPTY) begin
               winner_d    = vc_winner;
               game_over_d = 1'b1;
               state_d     = ST_OVER;
            end else if (move_cnt_q == MAX_MOVES) begin
               winner_d    = PIECE_DRAW;
               game_over_d = 1'b1;
               state_d     = ST_OVER;
            end else begin
               player_d = other_player(player_q);
               state_d  = ST_IDLE;
            end
         end
         ST_OVER: state_d = ST_OVER;
         default: state_d = ST_IDLE;
      endcase

      if (new_game) begin
         state_d     = ST_IDLE;
         player_d    = PIECE_P1;
         winner_d    = PIECE_EMPTY;
         game_over_d = 1'b0;
         move_cnt_d  = '0;
         wr_en_d     = 1'b0;
         vc_start_d  = 1'b0;
         illegal_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         col_q       <= 3'd0;
         scan_row_q  <= 3'd0;
         land_row_q  <= 3'd0;
         land_col_q  <= 3'd0;
         player_q    <= PIECE_P1;
         winner_q    <= PIECE_EMPTY;
         game_over_q <= 1'b0;
         move_cnt_q  <= '0;
         wr_en_q     <= 1'b0;
         vc_start_q  <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         scan_row_q  <= scan_row_d;
         land_row_q  <= land_row_d;
         land_col_q  <= land_col_d;
         player_q    <= player_d;
         winner_q    <= winner_d;
         game_over_q <= game_over_d;
         move_cnt_q  <= move_cnt_d;
         wr_en_q     <= wr_en_d;
         vc_start_q  <= vc_start_d;
         illegal_q   <= illegal_d;
      end
   end

   // The checker owns the read port from its start pulse until it reports done.
   always_comb begin
      rd_row = scan_row_q;
      rd_col = col_q;
      if (state_q inside {ST_CHECK_START, ST_WAIT_BUSY, ST_WAIT_DONE}) begin
         rd_row = vc_row_read;
         rd_col = vc_col_read;
      end
   end

   assign move_ready     = (state_q == ST_IDLE);
   assign illegal_move   = illegal_q;
   assign wr_en          = wr_en_q;
   assign wr_row         = land_row_q;
   assign wr_col         = land_col_q;
   // The player only changes in ST_RESOLVE, so it is stable across the write.
   assign wr_data        = player_q;
   assign vc_start       = vc_start_q;
   assign vc_row         = land_row_q;
   assign vc_col         = land_col_q;
   assign current_player = player_q;
   assign winner         = winner_q;
   assign game_over      = game_over_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a board RAM model and a simple
// victory_checker model whose result is set per scenario.
module tb_move_sequencer;

   localparam int BUDGET = 60;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       new_game;
   logic       move_valid;
   logic [2:0] move_col;
   logic       move_ready;
   logic       illegal_move;
   logic [2:0] rd_row, rd_col;
   logic [1:0] rd_data;
   logic       wr_en;
   logic [2:0] wr_row, wr_col;
   logic [1:0] wr_data;
   logic       vc_start;
   logic [2:0] vc_row, vc_col;
   logic [2:0] vc_row_read, vc_col_read;
   logic       vc_done;
   logic [1:0] vc_winner;
   logic [1:0] current_player;
   logic [1:0] winner;
   logic       game_over;

   int vectors = 0;
   int miscompares = 0;

   logic [1:0] model_win;
   logic [1:0] board [8][8];
   int         busy_cnt;

   // results of the last do_move
   int         r_wr_cnt, r_wr_cycle, r_vcs_cycle, r_ill_cycle, r_end_cycle;
   logic [2:0] r_wr_row, r_wr_col;
   logic [1:0] r_wr_data;
   logic       r_scan_rd_ok, r_chk_rd_ok;

   always #5 clk = ~clk;

   move_sequencer dut (
      .clk(clk), .rst_n(rst_n), .new_game(new_game),
      .move_valid(move_valid), .move_col(move_col), .move_ready(move_ready),
      .illegal_move(illegal_move), .rd_row(rd_row), .rd_col(rd_col),
      .rd_data(rd_data), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
      .wr_data(wr_data), .vc_start(vc_start), .vc_row(vc_row), .vc_col(vc_col),
      .vc_row_read(vc_row_read), .vc_col_read(vc_col_read), .vc_done(vc_done),
      .vc_winner(vc_winner), .current_player(current_player), .winner(winner),
      .game_over(game_over)
   );

   assign rd_data = board[rd_row][rd_col];

   always @(posedge clk) begin
      if (new_game) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               board[i][j] <= 2'b00;
      end else if (wr_en) begin
         board[wr_row][wr_col] <= wr_data;
      end
   end

   // Checker model: goes busy the cycle after start, done 4 cycles later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vc_done   <= 1'b1;
         vc_winner <= 2'b00;
         busy_cnt  <= 0;
      end else if (vc_start && vc_done) begin
         vc_done   <= 1'b0;
         vc_winner <= 2'b00;
         busy_cnt  <= 3;
      end else if (!vc_done) begin
         if (busy_cnt == 0) begin
            vc_done   <= 1'b1;
            vc_winner <= model_win;
         end else begin
            busy_cnt <= busy_cnt - 1;
         end
      end
   end

   task automatic pulse_new_game();
      @(negedge clk);
      new_game = 1'b1;
      @(posedge clk);
      #1 new_game = 1'b0;
   endtask

   // Cycle n counts from the acceptance edge; sampled on negedges.
   task automatic do_move(input logic [2:0] col);
      r_wr_cnt = 0; r_wr_cycle = -1; r_vcs_cycle = -1; r_ill_cycle = -1; r_end_cycle = -1;
      r_wr_row = '0; r_wr_col = '0; r_wr_data = '0; r_scan_rd_ok = 1'b0; r_chk_rd_ok = 1'b0;
      @(negedge clk);
      vectors++;
      if (move_ready !== 1'b1) begin
         miscompares++; $display("FAIL ready_before_move: got %b want 1", move_ready);
      end
      move_valid = 1'b1;
      move_col   = col;
      @(posedge clk);
      #1 move_valid = 1'b0;
      for (int n = 1; n <= BUDGET; n++) begin
         @(negedge clk);
         if (n == 1) r_scan_rd_ok = (rd_row == 3'd0) && (rd_col == col);
         if (wr_en === 1'b1) begin
            r_wr_cnt++; r_wr_cycle = n;
            r_wr_row = wr_row; r_wr_col = wr_col; r_wr_data = wr_data;
         end
         if (vc_start === 1'b1) begin
            r_vcs_cycle = n;
            r_chk_rd_ok = (rd_row == vc_row_read) && (rd_col == vc_col_read);
         end
         if (illegal_move === 1'b1) r_ill_cycle = n;
         if (move_ready === 1'b1 || game_over === 1'b1) begin
            r_end_cycle = n;
            break;
         end
      end
      if (r_end_cycle < 0) begin
         vectors++; miscompares++;
         $display("FAIL move_timeout: no return to idle within %0d cycles", BUDGET);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++; if (current_player !== 2'b01) begin miscompares++; $display("FAIL rst_player: got %b want 01", current_player); end
      vectors++; if (winner !== 2'b00) begin miscompares++; $display("FAIL rst_winner: got %b want 00", winner); end
      vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL rst_game_over: got %b want 0", game_over); end
      vectors++; if (move_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", move_ready); end
      vectors++; if ({wr_en, vc_start, illegal_move} !== 3'b000) begin
         miscompares++; $display("FAIL rst_strobes: got %b want 000", {wr_en, vc_start, illegal_move});
      end
   endtask

   task automatic test_empty_drop();
      do_move(3'd3);
      vectors++; if (r_wr_cnt != 1 || r_wr_cycle != 2) begin miscompares++; $display("FAIL empty_wr_timing: got cnt %0d cycle %0d want 1/2", r_wr_cnt, r_wr_cycle); end
      vectors++; if ({r_wr_row, r_wr_col, r_wr_data} !== {3'd0, 3'd3, 2'b01}) begin
         miscompares++; $display("FAIL empty_wr_addr: got row %0d col %0d data %b want 0/3/01", r_wr_row, r_wr_col, r_wr_data);
      end
      vectors++; if (r_vcs_cycle != 3) begin miscompares++; $display("FAIL empty_vc_start: got cycle %0d want 3", r_vcs_cycle); end
      vectors++; if (!r_scan_rd_ok) begin miscompares++; $display("FAIL scan_rd_mux: got %0d/%0d want 0/3", rd_row, rd_col); end
      vectors++; if (!r_chk_rd_ok) begin miscompares++; $display("FAIL check_rd_mux: checker address not routed to rd port (want 5/6)"); end
      vectors++; if (current_player !== 2'b10) begin miscompares++; $display("FAIL empty_turn: got %b want 10", current_player); end
   endtask

   task automatic test_stacked_drop();
      do_move(3'd3);
      vectors++; if ({r_wr_row, r_wr_data} !== {3'd1, 2'b10} || r_wr_cycle != 3) begin
         miscompares++; $display("FAIL stack1: got row %0d data %b cycle %0d want 1/10/3", r_wr_row, r_wr_data, r_wr_cycle);
      end
      do_move(3'd3);
      vectors++; if ({r_wr_row, r_wr_col, r_wr_data} !== {3'd2, 3'd3, 2'b01} || r_wr_cycle != 4) begin
         miscompares++; $display("FAIL stack2: got row %0d col %0d data %b cycle %0d want 2/3/01/4", r_wr_row, r_wr_col, r_wr_data, r_wr_cycle);
      end
      vectors++; if (r_vcs_cycle != 5) begin miscompares++; $display("FAIL stack2_vc_start: got %0d want 5", r_vcs_cycle); end
      vectors++; if (vc_row !== 3'd2 || vc_col !== 3'd3) begin miscompares++; $display("FAIL stack2_vc_pos: got %0d/%0d want 2/3", vc_row, vc_col); end
   endtask

   task automatic test_illegal();
      for (int k = 0; k < 6; k++) do_move(3'd5);
      vectors++; if (r_wr_row !== 3'd5) begin miscompares++; $display("FAIL fill_top: got row %0d want 5", r_wr_row); end
      do_move(3'd5);
      vectors++; if (r_ill_cycle != 7 || r_wr_cnt != 0) begin
         miscompares++; $display("FAIL full_col: got ill cycle %0d writes %0d want 7/0", r_ill_cycle, r_wr_cnt);
      end
      vectors++; if (current_player !== 2'b10) begin miscompares++; $display("FAIL full_col_turn: got %b want 10", current_player); end
      do_move(3'd7);
      vectors++; if (r_ill_cycle != 1 || r_end_cycle != 1 || r_wr_cnt != 0) begin
         miscompares++; $display("FAIL bad_col: got ill %0d end %0d writes %0d want 1/1/0", r_ill_cycle, r_end_cycle, r_wr_cnt);
      end
   endtask

   task automatic test_win();
      int writes;
      model_win = 2'b01;
      do_move(3'd0);
      @(negedge clk);
      vectors++; if (winner !== 2'b01 || game_over !== 1'b1) begin
         miscompares++; $display("FAIL win_result: got winner %b over %b want 01/1", winner, game_over);
      end
      vectors++; if (move_ready !== 1'b0) begin miscompares++; $display("FAIL win_ready: got %b want 0", move_ready); end
      model_win  = 2'b00;
      writes     = 0;
      move_valid = 1'b1;
      move_col   = 3'd1;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (wr_en === 1'b1 || illegal_move === 1'b1) writes++;
      end
      vectors++; if (writes != 0 || game_over !== 1'b1 || move_ready !== 1'b0) begin
         miscompares++; $display("FAIL over_ignores_move: got activity %0d over %b ready %b want 0/1/0", writes, game_over, move_ready);
      end
      pulse_new_game();
      move_valid = 1'b0;
      @(negedge clk);
      vectors++; if ({move_ready, current_player, winner, game_over} !== {1'b1, 2'b01, 2'b00, 1'b0}) begin
         miscompares++; $display("FAIL new_game_clear: got ready %b player %b winner %b over %b want 1/01/00/0",
                                 move_ready, current_player, winner, game_over);
      end
   endtask

   task automatic test_draw_and_abort();
      int ill_seen;
      int seen;
      ill_seen = 0;
      for (int c = 0; c < 7; c++)
         for (int k = 0; k < 6; k++) begin
            do_move(3'(c));
            if (r_ill_cycle >= 0) ill_seen++;
         end
      @(negedge clk);
      vectors++; if (ill_seen != 0) begin miscompares++; $display("FAIL draw_fill: got %0d illegal pulses want 0", ill_seen); end
      vectors++; if (winner !== 2'b11 || game_over !== 1'b1) begin
         miscompares++; $display("FAIL draw_result: got winner %b over %b want 11/1", winner, game_over);
      end
      vectors++; if (current_player !== 2'b10) begin miscompares++; $display("FAIL draw_player: got %b want 10", current_player); end
      pulse_new_game();
      repeat (8) @(negedge clk);
      // new_game while the checker is busy
      move_valid = 1'b1;
      move_col   = 3'd2;
      @(posedge clk);
      #1 move_valid = 1'b0;
      seen = 0;
      for (int n = 0; n < BUDGET && seen == 0; n++) begin
         @(negedge clk);
         if (vc_start === 1'b1) seen = 1;
      end
      vectors++; if (seen == 0) begin miscompares++; $display("FAIL abort_vc_start: got none want pulse"); end
      repeat (2) @(negedge clk);
      new_game = 1'b1;
      @(posedge clk);
      #1 new_game = 1'b0;
      @(negedge clk);
      vectors++; if ({move_ready, current_player, winner, game_over} !== {1'b1, 2'b01, 2'b00, 1'b0}) begin
         miscompares++; $display("FAIL abort_clear: got ready %b player %b winner %b over %b want 1/01/00/0",
                                 move_ready, current_player, winner, game_over);
      end
      repeat (10) @(negedge clk);
      do_move(3'd2);
      vectors++; if (r_wr_row !== 3'd0 || current_player !== 2'b10 || game_over !== 1'b0) begin
         miscompares++; $display("FAIL after_abort: got row %0d player %b over %b want 0/10/0", r_wr_row, current_player, game_over);
      end
   endtask

   task automatic test_reset_mid_move();
      int wr_seen;
      @(negedge clk);
      move_valid = 1'b1;
      move_col   = 3'd2;
      @(posedge clk);
      #1 move_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++; if ({move_ready, wr_en, vc_start, illegal_move, current_player, winner, game_over} !==
                     {1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0}) begin
         miscompares++; $display("FAIL reset_in_scan: got ready %b wr %b vcs %b ill %b player %b winner %b over %b",
                                 move_ready, wr_en, vc_start, illegal_move, current_player, winner, game_over);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      move_valid = 1'b1;
      move_col   = 3'd4;
      @(posedge clk);
      #1 move_valid = 1'b0;
      repeat (2) @(negedge clk);
      wr_seen = (wr_en === 1'b1) ? 1 : 0;
      rst_n = 1'b0;
      #1;
      vectors++; if (wr_seen != 1 || wr_en !== 1'b0) begin
         miscompares++; $display("FAIL reset_in_write: got strobe before %0d after %b want 1/0", wr_seen, wr_en);
      end
      @(posedge clk);
      #1;
      vectors++; if (board[0][4] !== 2'b00) begin miscompares++; $display("FAIL write_dropped: got cell %b want 00", board[0][4]); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      new_game    = 1'b0;
      move_valid  = 1'b0;
      move_col    = 3'd0;
      vc_row_read = 3'd5;
      vc_col_read = 3'd6;
      model_win   = 2'b00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      pulse_new_game();
      test_empty_drop();
      test_stacked_drop();
      test_illegal();
      test_win();
      test_draw_and_abort();
      test_reset_mid_move();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
